// File: rtl/ripple_ctrl_pkg.sv
// Shared types and helpers for the ripple counter sequencer.
package ripple_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StSettle,
        StCheck,
        StPulseHi,
        StPulseLo,
        StDone
    } state_e;

    // Bits needed to hold the longest wait, settle or pulse.
    function automatic int unsigned tmr_width(input int unsigned settle, input int unsigned pulse);
        int unsigned longest;
        longest = (settle > pulse) ? settle : pulse;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module cycle_timer #(
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ripple_count_ctrl.sv
// Sequencer that clears a ripple counter, pulses it up to a target and checks every step.
module ripple_count_ctrl #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned PULSE  = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] count_in,
    output logic             count_clk,
    output logic             count_clear,
    output logic [WIDTH-1:0] count_q,
    output logic             busy,
    output logic             done,
    output logic             error
);
    import ripple_ctrl_pkg::*;

    localparam int unsigned TW = tmr_width(SETTLE, PULSE);

    state_e           state_d, state_q;
    logic [WIDTH-1:0] tgt_d, tgt_q;
    logic [WIDTH-1:0] exp_d, exp_q;
    logic [WIDTH-1:0] samp_d, samp_q;
    logic             error_d, error_q;
    logic             cclk_d, cclk_q;
    logic             clear_d, clear_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             tmr_load, tmr_zero;
    logic [TW-1:0]    tmr_val;

    cycle_timer #(
        .Width (TW)
    ) u_timer (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        exp_d   = exp_q;
        samp_d  = samp_q;
        error_d = error_q;
        // Abort beats everything, including a start in the same cycle.
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_d = StClear;
                        tgt_d   = target;
                        exp_d   = '0;
                        error_d = 1'b0;
                    end
                end
                StClear:   state_d = StSettle;
                StSettle:  if (tmr_zero) state_d = StCheck;
                StCheck: begin
                    samp_d = count_in;
                    if (count_in != exp_q) begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end else if (exp_q == tgt_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StPulseHi;
                        exp_d   = exp_q + WIDTH'(1);
                    end
                end
                StPulseHi: if (tmr_zero) state_d = StPulseLo;
                StPulseLo: if (tmr_zero) state_d = StSettle;
                default:   state_d = StIdle;
            endcase
        end
    end

    // Timer is reloaded with length-1 on entry so each wait lasts exactly its length.
    always_comb begin
        tmr_load = (state_d != state_q) &&
                   (state_d inside {StSettle, StPulseHi, StPulseLo});
        tmr_val  = (state_d == StSettle) ? TW'(SETTLE - 1) : TW'(PULSE - 1);
        cclk_d   = (state_d == StPulseHi);
        clear_d  = (state_d == StClear);
        done_d   = (state_d == StDone);
        busy_d   = !(state_d inside {StIdle, StDone});
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            tgt_q   <= '0;
            exp_q   <= '0;
            samp_q  <= '0;
            error_q <= 1'b0;
            cclk_q  <= 1'b0;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            exp_q   <= exp_d;
            samp_q  <= samp_d;
            error_q <= error_d;
            cclk_q  <= cclk_d;
            clear_q <= clear_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign count_clk   = cclk_q;
    assign count_clear = clear_q;
    assign count_q     = samp_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule
